seq_gen: RTL and testbench
==========================

# seq_gen

Parametrised output-sequence generator. It steps through a programmable table of WIDTH-bit values and holds each value for a per-entry dwell time. It supports one-shot and looping playback, start/stop control and runtime table writes. Successor to the fixed 0-5-1-3-6 sequencer with its hardwired 3-cycle dwell; its reset-default table and AUTO_START reproduce that sequence.

## Interface
Parameters:
- WIDTH, 3, bit width of each output value
- DEPTH, 8, number of table entries (≥5); AW = $clog2(DEPTH), LW = $clog2(DEPTH+1)
- DWELL_W, 4, dwell field width; an entry is shown dwell+1 cycles
- AUTO_START, 1, 1 = enter RUN in looping mode straight out of reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  begin playback from entry 0 (ignored while busy)
- stop  in  1  abort playback
- loop  in  1  1 = wrap to entry 0 after last entry; 0 = one-shot
- seq_len  in  LW  number of entries played; sampled on start
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write index
- wr_value  in  WIDTH  value to store
- wr_dwell  in  DWELL_W  dwell to store
- number  out  WIDTH  current output value (registered)
- step  out  AW  index of entry currently shown
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at one-shot completion

## Operation
- FSM states: IDLE, RUN.
- IDLE→RUN on start (or on first clk after reset release if AUTO_START=1; loop treated as 1 for that auto run until first wrap decision, then live). RUN→IDLE on stop or one-shot end.
- Reset: number=0, step=0, busy=0, done=0, dwell counter=0, len register=5. Table defaults: values 0,5,1,3,6 at entries 0–4 with dwells 0,0,0,2,0; entries 5..DEPTH-1 = 0/0. Values are truncated to WIDTH.
- seq_len=0 or >DEPTH → DEPTH entries.
- On each entry load: number←table[step].value, dwell counter←table[step].dwell. The counter decrements each cycle; at zero, advance.
- Advance from last entry (step==len-1): loop=1 → step 0; loop=0 → IDLE, done=1 for that cycle, busy=0. number and step hold the last entry.
- stop in RUN: next cycle IDLE, busy=0, done stays 0, number held.
- start and stop in the same cycle: stop wins; start is ignored.
- Writes are accepted in any state, one entry per cycle. A write to the entry currently shown does not change number until that entry is loaded again.
- Write and load of the same entry in the same cycle: the load sees the old contents.

## Timing
- start sampled at edge N: busy=1, step=0, number=table[0].value after edge N.
- Entry with dwell d is visible exactly d+1 cycles. Full pass = Σ(d_i+1) cycles.
- One-shot: done asserted in the cycle after the last entry's final dwell cycle, coincident with busy falling.
- The loop input is sampled at the wrap-decision edge only.
- Async rst assertion forces all reset values immediately, including mid-run. This also restores the default table.
- Maximum dwell: 2^DWELL_W cycles per entry.

## Structure
- Package seq_gen_pkg holds the state enum and the default value/dwell constant arrays.
- Sub-module dwell_counter contains the DWELL_W down-counter, with load, enable and a zero flag.
- Table is a flop array (DEPTH×(WIDTH+DWELL_W)). No RAM macro.

## Test plan
- Reset with AUTO_START=1, no stimulus → number 0,5,1,3,3,3,6,0,5… (seven-cycle period), busy=1.
- AUTO_START=0, write entries 0–2 = 2/dwell1, 7/dwell0, 4/dwell3; seq_len=3, loop=0, start → 2,2,7,4,4,4,4. Then done pulse, busy=0, number holds 4.
- Loop=1, run, deassert loop mid-pass → completes current pass, then done, IDLE.
- stop during dwell of entry 1 → busy=0 next cycle, done never pulses. Simultaneous start+stop in IDLE → stays IDLE.
- seq_len=0 with DEPTH=8 → all 8 entries played. Write entry 3 while entry 3 is shown → output unchanged until next pass.
- rst pulse mid-run → number=0, busy=0 immediately. Default table restored; 0,5,1,3 sequence replays after release.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and the reset-default table for the sequence generator.
// The default table reproduces the legacy 0-5-1-3-6 pattern.
package seq_gen_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam int DEF_N = 5;

  localparam int DEF_VAL [DEF_N] = '{0, 5, 1, 3, 6};
  localparam int DEF_DWELL [DEF_N] = '{0, 0, 0, 2, 0};

  // Entries past the legacy pattern default to value 0, dwell 0
  function automatic int def_val(input int i);
    return (i < DEF_N) ? DEF_VAL[i % DEF_N] : 0;
  endfunction

  function automatic int def_dwell(input int i);
    return (i < DEF_N) ? DEF_DWELL[i % DEF_N] : 0;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Down-counter holding the remaining dwell of the shown entry.
// Load wins over decrement; the counter parks at zero.
module dwell_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_gen.sv
// Programmable sequence generator: plays a table of values, each held
// for its own dwell, in one-shot or looping mode.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int DEPTH      = 8,
  parameter int DWELL_W    = 4,
  parameter bit AUTO_START = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [LW-1:0]      seq_len,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_value,
  input  logic [DWELL_W-1:0] wr_dwell,
  output logic [WIDTH-1:0]   number,
  output logic [AW-1:0]      step,
  output logic               busy,
  output logic               done
);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_tval [DEPTH];
  logic [DWELL_W-1:0] r_tdw  [DEPTH];

  logic [WIDTH-1:0] r_number;
  logic [AW-1:0]    r_step;
  logic [LW-1:0]    r_len;
  logic             r_done;
  logic             r_auto;
  logic             r_force_loop;

  logic               w_zero;
  logic               w_last;
  logic               w_load;
  logic               w_go;
  logic               w_wrap;
  logic               w_done_nxt;
  logic               w_cnt_en;
  logic [AW-1:0]      w_idx;
  logic [LW-1:0]      w_len_in;
  logic [DWELL_W-1:0] w_ld_dwell;

  assign w_len_in = ((seq_len == '0) || (seq_len > LW'(DEPTH)))
                  ? LW'(DEPTH) : seq_len;

  assign w_last = (LW'(r_step) == (r_len - LW'(1)));

  assign w_cnt_en = (r_state == S_RUN) && !stop;

  assign w_ld_dwell = r_tdw[w_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_idx       = '0;
    w_go        = 1'b0;
    w_wrap      = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!stop && (start || r_auto)) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
          w_go        = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_zero) begin
          if (!w_last) begin
            w_load = 1'b1;
            w_idx  = r_step + AW'(1);
          end else begin
            w_wrap = 1'b1;
            if (loop || r_force_loop) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Auto-start plays with the reset length and forced looping
  // until its first wrap decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_number     <= '0;
      r_step       <= '0;
      r_len        <= LW'(DEF_N);
      r_done       <= 1'b0;
      r_auto       <= AUTO_START;
      r_force_loop <= 1'b0;
    end else begin
      r_auto <= 1'b0;
      r_done <= w_done_nxt;
      if (w_load) begin
        r_number <= r_tval[w_idx];
        r_step   <= w_idx;
      end
      if (w_go && start) begin
        r_len <= w_len_in;
      end
      if (w_go) begin
        r_force_loop <= r_auto && !start;
      end else if (w_wrap || stop) begin
        r_force_loop <= 1'b0;
      end
    end
  end

  // Loads read the table before this edge's write lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tval[i] <= WIDTH'(def_val(i));
        r_tdw[i]  <= DWELL_W'(def_dwell(i));
      end
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      r_tval[wr_addr] <= wr_value;
      r_tdw[wr_addr]  <= wr_dwell;
    end
  end

  dwell_counter #(
    .W(DWELL_W)
  ) u_dwell (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_load),
    .i_val   (w_ld_dwell),
    .i_en    (w_cnt_en),
    .o_zero  (w_zero)
  );

  assign number = r_number;
  assign step   = r_step;
  assign busy   = (r_state == S_RUN);
  assign done   = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: per-cycle reference model plus directed
// scenarios with hand-computed expectations.
module tb_seq_gen;

  localparam int WIDTH   = 3;
  localparam int DEPTH   = 8;
  localparam int DWELL_W = 4;
  localparam int AW      = 3;
  localparam int LW      = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               loop;
  logic [LW-1:0]      seq_len;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_value;
  logic [DWELL_W-1:0] wr_dwell;

  logic [WIDTH-1:0] number;
  logic [AW-1:0]    step;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] a_number;
  logic [AW-1:0]    a_step;
  logic             a_busy;
  logic             a_done;

  int n_vec = 0;
  int n_err = 0;

  int aseq [7]  = '{0, 5, 1, 3, 3, 3, 6};
  int astep [7] = '{0, 1, 2, 3, 3, 3, 4};
  int os [7]    = '{2, 2, 7, 4, 4, 4, 4};
  int rs [6]    = '{0, 5, 1, 3, 3, 3};

  always #5 clk = ~clk;

  seq_gen #(
    .AUTO_START(1'b0)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .seq_len  (seq_len),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_value (wr_value),
    .wr_dwell (wr_dwell),
    .number   (number),
    .step     (step),
    .busy     (busy),
    .done     (done)
  );

  seq_gen #(
    .AUTO_START(1'b1)
  ) u_auto (
    .clk      (clk),
    .rst      (rst),
    .start    (1'b0),
    .stop     (1'b0),
    .loop     (1'b1),
    .seq_len  (4'd0),
    .wr_en    (1'b0),
    .wr_addr  (3'd0),
    .wr_value (3'd0),
    .wr_dwell (4'd0),
    .number   (a_number),
    .step     (a_step),
    .busy     (a_busy),
    .done     (a_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each shown entry has a count of visible cycles left
  int m_val [DEPTH];
  int m_dw  [DEPTH];
  int m_number;
  int m_step;
  int m_left;
  int m_len;
  int m_busy;
  int m_done;

  task automatic m_show(input int i);
    m_step   = i;
    m_number = m_val[i];
    m_left   = m_dw[i] + 1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_val    = '{0, 5, 1, 3, 6, 0, 0, 0};
      m_dw     = '{0, 0, 0, 2, 0, 0, 0, 0};
      m_number = 0;
      m_step   = 0;
      m_left   = 0;
      m_len    = 5;
      m_busy   = 0;
      m_done   = 0;
    end else begin
      m_done = 0;
      if (m_busy == 0) begin
        if (start && !stop) begin
          m_len  = (seq_len == 0 || seq_len > DEPTH) ? DEPTH : int'(seq_len);
          m_busy = 1;
          m_show(0);
        end
      end else if (stop) begin
        m_busy = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_step == m_len - 1) begin
            if (loop) begin
              m_show(0);
            end else begin
              m_busy = 0;
              m_done = 1;
            end
          end else begin
            m_show(m_step + 1);
          end
        end
      end
      if (wr_en) begin
        m_val[wr_addr] = int'(wr_value);
        m_dw[wr_addr]  = int'(wr_dwell);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_number", int'(number), m_number);
    chk("m_step", int'(step), m_step);
    chk("m_busy", int'(busy), m_busy);
    chk("m_done", int'(done), m_done);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input int v, input int d);
    wr_en    = 1'b1;
    wr_addr  = AW'(a);
    wr_value = WIDTH'(v);
    wr_dwell = DWELL_W'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    loop     = 1'b0;
    seq_len  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_value = '0;
    wr_dwell = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_number", int'(number), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_auto_busy", int'(a_busy), 0);

    // auto-start: legacy 7-cycle pattern
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("auto_pre_num", int'(a_number), 0);
    chk("auto_pre_busy", int'(a_busy), 0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("auto_num", int'(a_number), aseq[k % 7]);
      chk("auto_step", int'(a_step), astep[k % 7]);
      chk("auto_busy", int'(a_busy), 1);
    end
    chk("idle_no_auto", int'(busy), 0);

    // one-shot of three programmed entries
    wr(0, 2, 1);
    wr(1, 7, 0);
    wr(2, 4, 3);
    seq_len = 4'd3;
    loop    = 1'b0;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("os_num", int'(number), os[k]);
    end
    @(negedge clk);
    chk("os_done", int'(done), 1);
    chk("os_busy", int'(busy), 0);
    chk("os_hold", int'(number), 4);
    @(negedge clk);
    chk("os_done_clr", int'(done), 0);
    chk("os_hold2", int'(number), 4);

    // looping, loop dropped mid second pass
    loop  = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (8) cyc();
    loop = 1'b0;
    repeat (6) @(negedge clk);
    chk("lp_not_yet", int'(done), 0);
    @(negedge clk);
    chk("lp_done", int'(done), 1);
    chk("lp_busy", int'(busy), 0);
    chk("lp_num", int'(number), 4);

    // stop during dwell of entry 1
    wr(1, 7, 2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    @(negedge clk);
    chk("stp_busy", int'(busy), 0);
    chk("stp_done", int'(done), 0);
    chk("stp_num", int'(number), 7);
    chk("stp_step", int'(step), 1);
    repeat (3) begin
      @(negedge clk);
      chk("stp_nodone", int'(done), 0);
    end

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    chk("ss_busy", int'(busy), 0);
    chk("ss_num", int'(number), 7);

    // full-depth one-shot, max dwell, write to the shown entry
    wr(3, 1, 2);
    wr(4, 6, 0);
    wr(5, 3, 15);
    wr(6, 5, 0);
    wr(7, 0, 1);
    seq_len = 4'd0;
    loop    = 1'b0;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    repeat (9) cyc();
    wr(3, 5, 2);
    @(negedge clk);
    chk("wr_shown", int'(number), 1);
    @(negedge clk);
    chk("wr_shown2", int'(number), 1);
    @(negedge clk);
    chk("wr_next", int'(number), 6);
    repeat (19) @(negedge clk);
    chk("full_last_busy", int'(busy), 1);
    chk("full_last_step", int'(step), 7);
    @(negedge clk);
    chk("full_done", int'(done), 1);
    chk("full_busy", int'(busy), 0);

    // seq_len above DEPTH plays all entries; rewritten entry 3 now shows
    seq_len = 4'd9;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("wr_new_num", int'(number), 5);
    chk("wr_new_step", int'(step), 3);
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    chk("len9_done", int'(done), 1);

    // async reset mid-run restores the default table
    seq_len = 4'd0;
    loop    = 1'b1;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    rst = 1'b0;
    #1;
    chk("ar_num", int'(number), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_step", int'(step), 0);
    chk("ar_auto_busy", int'(a_busy), 0);
    cyc();
    rst     = 1'b1;
    seq_len = 4'd4;
    loop    = 1'b0;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rs_num", int'(number), rs[k]);
      if (k == 0) chk("auto_restart", int'(a_busy), 1);
    end
    @(negedge clk);
    chk("rs_done", int'(done), 1);
    chk("rs_hold", int'(number), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
